alu_32_bit: RTL and testbench
=============================

Name: alu_32_bit

Overview:
32-bit integer ALU with MIPS-style 3-bit operation select: AND, OR, ADD, SUB and signed set-less-than.
Combinational datapath is a ripple-carry chain of 1-bit ALU slices; result and zero flag are registered.
Sits in the execute stage of the CPU datapath, driven by the ALU control unit.

Parameters:
None. Width is fixed at 32 bits and the opcode is fixed at 3 bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
i1  input  32  operand A
i2  input  32  operand B
alu_op_select  input  3  operation select (encodings below)
zero_bit  output  1  registered: 1 when registered out equals 0
out  output  32  registered ALU result

Behaviour:
- Reset: rst high asynchronously forces out=32'h0 and zero_bit=1. Both hold while rst is high.
- Release: the first capture happens on the first rising clk edge after rst falls.
- Latency: 1 cycle. Inputs sampled at rising clk edge N appear on out/zero_bit after edge N. No handshake; a new operation may start every cycle.
- Opcodes:
  - 000 AND: out = i1 & i2.
  - 001 OR: out = i1 | i2.
  - 010 ADD: out = i1 + i2, modulo 2^32.
  - 110 SUB: out = i1 - i2, computed as i1 + ~i2 + 1 with carry-in 1 on slice 0; modulo 2^32.
  - 111 SLT: out = {31'b0, lt}, where lt = 1 iff $signed(i1) < $signed(i2).
  - 011, 100, 101 (unused): out = 32'h0.
- Opcode bit decode:
  - alu_op_select[2] is binvert: it inverts B in every slice and drives carry-in to slice 0.
  - alu_op_select[1:0] selects the slice output: 00 AND, 01 OR, 10 SUM, 11 LESS.
- SLT computation: lt = sum[31] XOR overflow of the subtraction. It must be correct when A-B overflows, e.g. i1=32'h80000000, i2=1 gives 1.
  - overflow = carry_in[31] XOR carry_out[31].
  - The LESS input of slice 0 is lt; the LESS inputs of slices 1..31 are 0.
- No carry-out or overflow port; add/sub wrap silently.
- zero_bit is computed from the next-state result (NOR of all 32 result bits) and registered alongside out, so the two are always consistent in the same cycle.
- Operand or opcode changes between clock edges have no effect until the next edge; there are no glitches on outputs.
- Reset asserted mid-operation discards the in-flight result immediately (asynchronous).

Test Plan:
- rst=1 pulse asynchronously between edges -> out=0, zero_bit=1 immediately; after release with i1=9, i2=3, op=010, next edge -> out=12, zero_bit=0.
- i1=9, i2=3, sequencing op 010/110/000/001/111 on consecutive cycles -> out=12, 6, 1, 11, 0 respectively, each one cycle after issue; zero_bit=1 only for the SLT result.
- SLT signed: (3,9) -> 1; (32'hFFFFFFFF, 1) -> 1; (1, 32'hFFFFFFFF) -> 0; overflow case (32'h80000000, 1) -> 1; (32'h7FFFFFFF, 32'hFFFFFFFF) -> 0.
- Wrap: ADD 32'hFFFFFFFF + 1 -> out=0, zero_bit=1; SUB 0 - 1 -> 32'hFFFFFFFF, zero_bit=0; SUB 5 - 5 -> 0, zero_bit=1.
- Unused opcodes 011/100/101 with i1=32'hA5A5A5A5, i2=32'h5A5A5A5A -> out=0, zero_bit=1; AND gives 0, OR gives 32'hFFFFFFFF.
- Back-to-back randomized operands and opcodes for ≥1000 cycles, checked against a behavioural model with 1-cycle delay; rst asserted randomly mid-stream -> outputs reset immediately.

Source files
------------

// File: rtl/alu_32_bit.sv
// 32-bit MIPS-style ALU built from a ripple-carry chain of 1-bit slices.
// Result and zero flag are registered together; one-cycle latency.
module alu_32_bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i1,
  input  logic [31:0] i2,
  input  logic [2:0]  alu_op_select,
  output logic        zero_bit,
  output logic [31:0] out
);

  logic        binvert;
  logic [1:0]  slice_sel;
  logic        op_valid;
  logic [31:0] b_eff;
  logic [31:0] and_bits;
  logic [31:0] or_bits;
  logic [31:0] sum_bits;
  logic [32:0] carry;
  logic [31:0] slice_res;
  logic        lt;
  logic [31:0] out_d, out_q;
  logic        zero_d, zero_q;

  assign binvert   = alu_op_select[2];
  assign slice_sel = alu_op_select[1:0];

  // Only AND, OR, ADD, SUB and SLT are meaningful; every other code yields zero.
  always_comb begin
    op_valid = 1'b0;
    case (alu_op_select)
      3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_valid = 1'b1;
      default:                                op_valid = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_logic
    assign b_eff[gi]    = i2[gi] ^ binvert;
    assign and_bits[gi] = i1[gi] & b_eff[gi];
    assign or_bits[gi]  = i1[gi] | b_eff[gi];
  end

  // Ripple chain kept in one process so each slice's carry-in is its neighbour's carry-out.
  always_comb begin
    carry    = '0;
    sum_bits = '0;
    carry[0] = binvert;
    for (int k = 0; k < 32; k++) begin
      sum_bits[k]  = i1[k] ^ b_eff[k] ^ carry[k];
      carry[k + 1] = (i1[k] & b_eff[k]) | (carry[k] & (i1[k] ^ b_eff[k]));
    end
  end

  // Signed less-than: MSB of the difference corrected by two's-complement overflow.
  assign lt = sum_bits[31] ^ (carry[31] ^ carry[32]);

  for (genvar gi = 0; gi < 32; gi++) begin : g_slice_mux
    logic less_in;
    if (gi == 0) begin : g_less_lsb
      assign less_in = lt;
    end else begin : g_less_upper
      assign less_in = 1'b0;
    end

    always_comb begin
      case (slice_sel)
        2'b00:   slice_res[gi] = and_bits[gi];
        2'b01:   slice_res[gi] = or_bits[gi];
        2'b10:   slice_res[gi] = sum_bits[gi];
        default: slice_res[gi] = less_in;
      endcase
    end
  end

  assign out_d  = op_valid ? slice_res : 32'h0;
  assign zero_d = ~|out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= 32'h0;
      zero_q <= 1'b1;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
    end
  end

  assign out      = out_q;
  assign zero_bit = zero_q;

endmodule

// File: tb/tb_alu_32_bit.sv
// Directed and randomized self-checking bench for alu_32_bit.
// Each operation is issued on a falling edge and checked 1 ns after the next rising edge.
module tb_alu_32_bit;

  logic        clk;
  logic        rst;
  logic [31:0] i1;
  logic [31:0] i2;
  logic [2:0]  alu_op_select;
  logic        zero_bit;
  logic [31:0] out;

  int n_checks;
  int n_fail;

  alu_32_bit dut (
    .clk           (clk),
    .rst           (rst),
    .i1            (i1),
    .i2            (i2),
    .alu_op_select (alu_op_select),
    .zero_bit      (zero_bit),
    .out           (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  // Issue one operation, then check result and zero flag after the capturing edge.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    alu_op_select = op;
    i1 = a;
    i2 = b;
    @(posedge clk);
    #1;
    check_val({tag, "_out"}, out, exp);
    check_val({tag, "_zero"}, {31'b0, zero_bit}, {31'b0, (exp == 32'h0)});
    $display("op=%b a=%h b=%h out=%h zero=%b exp=%h", op, a, b, out, zero_bit, exp);
  endtask

  // Pulse reset between clock edges and confirm it acts without waiting for a clock.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_val({tag, "_rst_out"}, out, 32'h0);
    check_val({tag, "_rst_zero"}, {31'b0, zero_bit}, 32'd1);
    $display("reset pulse: out=%h zero=%b", out, zero_bit);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    i1            = 32'd9;
    i2            = 32'd3;
    alu_op_select = 3'b010;

    #3;
    check_val("init_out", out, 32'h0);
    check_val("init_zero", {31'b0, zero_bit}, 32'd1);
    @(posedge clk);
    #1;
    check_val("hold_out", out, 32'h0);
    check_val("hold_zero", {31'b0, zero_bit}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    run_op("rel_add", 3'b010, 32'd9, 32'd3, 32'd12);
    reset_pulse("mid");
    run_op("post_add", 3'b010, 32'd9, 32'd3, 32'd12);

    run_op("seq_add", 3'b010, 32'd9, 32'd3, 32'd12);
    run_op("seq_sub", 3'b110, 32'd9, 32'd3, 32'd6);
    run_op("seq_and", 3'b000, 32'd9, 32'd3, 32'd1);
    run_op("seq_or",  3'b001, 32'd9, 32'd3, 32'd11);
    run_op("seq_slt", 3'b111, 32'd9, 32'd3, 32'd0);

    run_op("slt_3_9",    3'b111, 32'd3,          32'd9,          32'd1);
    run_op("slt_m1_1",   3'b111, 32'hFFFFFFFF,   32'd1,          32'd1);
    run_op("slt_1_m1",   3'b111, 32'd1,          32'hFFFFFFFF,   32'd0);
    run_op("slt_ovf",    3'b111, 32'h80000000,   32'd1,          32'd1);
    run_op("slt_max_m1", 3'b111, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'd0);

    run_op("add_wrap", 3'b010, 32'hFFFFFFFF, 32'd1, 32'h0);
    run_op("sub_wrap", 3'b110, 32'd0,        32'd1, 32'hFFFFFFFF);
    run_op("sub_eq",   3'b110, 32'd5,        32'd5, 32'h0);

    run_op("op011", 3'b011, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0);
    run_op("op100", 3'b100, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0);
    run_op("op101", 3'b101, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0);
    run_op("and_cm", 3'b000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0);
    run_op("or_cm",  3'b001, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF);

    for (int n = 0; n < 1200; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0: a = 32'h80000000;
        1: b = 32'h7FFFFFFF;
        2: b = a;
        3: a = 32'hFFFFFFFF;
        default: ;
      endcase
      if ($urandom_range(0, 49) == 0) reset_pulse("rnd");
      run_op("rnd", op, a, b, model(op, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
